// File: rtl/led_seq_pkg.sv
// Shared constants and types for the LED index sequencer.
// Mode codes match the mode_sel encoding driven by the button logic.
package led_seq_pkg;

    localparam int unsigned DEF_IDX_W = 3;

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_PP     = 2'b10;
    localparam logic [1:0] MODE_FREEZE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    // Direction to adopt when switching into a mode; PP and FREEZE keep the current one.
    function automatic logic mode_dir(input logic [1:0] mode, input logic cur_dir);
        logic d;
        d = cur_dir;
        if (mode == MODE_UP) begin
            d = 1'b0;
        end else if (mode == MODE_DOWN) begin
            d = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/led_dwell_timer.sv
// Dwell counter: raises step_tick on the last tick of each step.
// Compares against the live dwell value so a shrinking dwell steps immediately.
module led_dwell_timer #(
    parameter int unsigned DW = 8
) (
    input  logic          clk1h,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic [DW-1:0] dwell,
    output logic          step_tick
);

    logic [DW-1:0] cnt_q;
    logic [DW-1:0] last;

    // dwell of 0 behaves as 1, so the last count is 0 in both cases.
    assign last      = (dwell == '0) ? '0 : dwell - DW'(1);
    assign step_tick = en && (cnt_q >= last);

    always_ff @(posedge clk1h or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= step_tick ? '0 : cnt_q + DW'(1);
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// Mode-controlled index generator feeding the 3-to-8 LED decoder.
// Run/hold FSM, up/down/ping-pong stepping and a req/ack mode-change handshake.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int unsigned IDX_W      = DEF_IDX_W,
    parameter int unsigned DW         = 8,
    parameter logic [1:0]  RESET_MODE = MODE_UP
) (
    input  logic             clk1h,
    input  logic             rst,
    input  logic             run_en,
    input  logic             clr,
    input  logic             mode_req,
    input  logic [1:0]       mode_sel,
    input  logic [DW-1:0]    dwell,
    output logic             mode_ack,
    output logic [IDX_W-1:0] idx,
    output logic             dir,
    output logic [1:0]       cur_mode,
    output logic             wrap,
    output logic             running
);

    localparam logic [IDX_W-1:0] IDX_MAX = '1;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             dir_q;
    logic [1:0]       mode_q;
    logic             ack_q;
    logic             wrap_q;

    logic             step_tick;
    logic             pending;
    logic             apply;
    logic             do_step;
    logic [1:0]       eff_mode;
    logic             eff_dir;
    logic [IDX_W-1:0] nxt_idx;
    logic             nxt_dir;
    logic             nxt_wrap;

    led_dwell_timer #(
        .DW(DW)
    ) u_timer (
        .clk1h    (clk1h),
        .rst      (rst),
        .en       (state_q == ST_RUN),
        .clr      (clr),
        .dwell    (dwell),
        .step_tick(step_tick)
    );

    always_comb begin
        // A request seen while ack is high is the one just served.
        pending  = mode_req && !ack_q;
        apply    = pending && ((state_q != ST_RUN) || step_tick);
        do_step  = (state_q == ST_RUN) && step_tick;
        eff_mode = apply ? mode_sel : mode_q;
        eff_dir  = apply ? mode_dir(mode_sel, dir_q) : dir_q;
        nxt_idx  = idx_q;
        nxt_dir  = eff_dir;
        nxt_wrap = 1'b0;
        case (eff_mode)
            MODE_UP: begin
                nxt_idx  = idx_q + IDX_W'(1);
                nxt_dir  = 1'b0;
                nxt_wrap = (idx_q == IDX_MAX);
            end
            MODE_DOWN: begin
                nxt_idx  = idx_q - IDX_W'(1);
                nxt_dir  = 1'b1;
                nxt_wrap = (idx_q == '0);
            end
            MODE_PP: begin
                if (!eff_dir) begin
                    if (idx_q == IDX_MAX) begin
                        nxt_idx = IDX_MAX - IDX_W'(1);
                        nxt_dir = 1'b1;
                    end else begin
                        nxt_idx = idx_q + IDX_W'(1);
                    end
                end else begin
                    if (idx_q == '0) begin
                        nxt_idx  = IDX_W'(1);
                        nxt_dir  = 1'b0;
                        nxt_wrap = 1'b1;
                    end else begin
                        nxt_idx = idx_q - IDX_W'(1);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk1h or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= RESET_MODE;
            ack_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            ack_q  <= 1'b0;
            wrap_q <= 1'b0;
            if (clr) begin
                // clr beats both a step and a pending request.
                state_q <= ST_IDLE;
                idx_q   <= '0;
                dir_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: if (run_en) state_q <= ST_RUN;
                    ST_RUN:  if (!run_en) state_q <= ST_HOLD;
                    ST_HOLD: if (run_en) state_q <= ST_RUN;
                    default: state_q <= ST_IDLE;
                endcase
                if (apply) begin
                    mode_q <= mode_sel;
                    ack_q  <= 1'b1;
                    dir_q  <= eff_dir;
                end
                if (do_step) begin
                    idx_q  <= nxt_idx;
                    dir_q  <= nxt_dir;
                    wrap_q <= nxt_wrap;
                end
            end
        end
    end

    assign mode_ack = ack_q;
    assign idx      = idx_q;
    assign dir      = dir_q;
    assign cur_mode = mode_q;
    assign wrap     = wrap_q;
    assign running  = (state_q == ST_RUN);

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
Sequencer for the 3-to-8 LED decode path. It replaces the free-running 3-bit counter with a mode-controlled index generator: up, down, ping-pong or freeze, with a programmable dwell of N clk1h ticks per step. A requester (button/debounce logic) changes mode through a req/ack handshake. The idx output feeds the 3-to-8 decoder's sw input directly.

Parameters:
IDX_W, 3, index width; index range 0..2^IDX_W-1 (MAX = 7 at default)
DW, 8, width of the dwell input and dwell counter
RESET_MODE, 2'b00, mode loaded at reset

Ports:
clk1h  in  1  step clock from the divider
rst  in  1  asynchronous, active-low reset
run_en  in  1  level; 1 = sequence advances, 0 = hold
clr  in  1  synchronous clear of the sequence position
mode_req  in  1  mode-change request, held until acked
mode_sel  in  2  requested mode: 00 UP, 01 DOWN, 10 PINGPONG, 11 FREEZE
dwell  in  DW  ticks per step; value 0 treated as 1
mode_ack  out  1  one-cycle acknowledge of mode_req
idx  out  IDX_W  current index to the decoder
dir  out  1  current direction, 0 = up, 1 = down
cur_mode  out  2  active mode
wrap  out  1  one-cycle pulse on pattern-cycle completion
running  out  1  high in the RUN state

Behaviour:
- Reset (rst low, async) values: idx=0, dir=0, cur_mode=RESET_MODE, mode_ack=0, wrap=0, running=0, dwell_cnt=0, state=IDLE.
- State machine:
  - IDLE -> RUN when run_en=1.
  - RUN -> HOLD when run_en=0.
  - HOLD -> RUN when run_en=1.
  - Any state -> IDLE on clr=1. clr sets idx=0, dir=0 and dwell_cnt=0; cur_mode is unchanged.
- Dwell:
  - D = max(dwell,1), sampled at every step boundary and on IDLE->RUN.
  - In RUN, dwell_cnt counts 0..D-1. A step occurs on the edge where dwell_cnt==D-1, and dwell_cnt then returns to 0.
  - In HOLD, dwell_cnt and idx are frozen. Counting resumes from the held value on return to RUN.
- Step rules (M = 2^IDX_W-1):
  - UP: idx+1 mod 2^IDX_W, dir=0. wrap pulses on M->0.
  - DOWN: idx-1 mod 2^IDX_W, dir=1. wrap pulses on 0->M.
  - PINGPONG: moves in direction dir.
    - At idx=M with dir=0: next idx is M-1 and dir becomes 1.
    - At idx=0 with dir=1: next idx is 1 and dir becomes 0; wrap pulses on this turn.
    - Full period is 2M steps (14 at default).
  - FREEZE: idx and dir unchanged, wrap never asserts.
- wrap is registered and high for exactly the one cycle following the step that caused it.
- Mode handshake:
  - A pending mode_req is applied in RUN only at a step boundary. That step is computed with the new mode.
  - When switching to UP, dir is forced to 0; to DOWN, dir is forced to 1; to PINGPONG, dir is kept.
  - In IDLE or HOLD, a request is applied on the next edge.
  - mode_ack is high for the single cycle after cur_mode updates.
  - The requester drops mode_req on seeing ack. mode_req is ignored while mode_ack=1, so one request produces exactly one ack.
  - Request with mode_sel equal to cur_mode: still acked, no other effect.
- Simultaneous events:
  - clr together with mode_req: clr wins; the request stays pending and is applied on the next edge in IDLE.
  - clr together with a step: no step, no wrap.
  - run_en falling on a step edge: the step completes and state goes to HOLD.
- Reset mid-operation: all outputs go to their reset values immediately. A pending request is dropped, and the requester re-issues it.
- Arithmetic is unsigned. The dwell compare uses DW bits, and dwell_cnt never exceeds D-1, even if dwell shrinks mid-step. If dwell_cnt >= new D-1 at sampling, the step occurs on that edge.

Decomposition:
- Package led_seq_pkg:
  - Mode constants MODE_UP, MODE_DOWN, MODE_PP, MODE_FREEZE (2 bits).
  - State encoding ST_IDLE, ST_RUN, ST_HOLD.
  - Default IDX_W.
- Sub-module led_dwell_timer: DW-bit counter with inputs en, clr and dwell; output step_tick; holds its count when en=0.
- Top level: FSM, index/direction update, handshake logic.

Test Plan:
- Reset, run_en=1, dwell=1, mode UP -> idx 0,1,...,7,0 on successive edges; wrap high only in the cycle after 7->0; running=1 from the first edge.
- dwell=3, UP -> idx advances every 3rd edge. dwell=0 -> behaves as dwell=1.
- Mode PINGPONG from idx=0, dwell=1 -> idx 1..7,6..0,1; dir flips after 7; wrap once per 14 steps at the 0 turn.
- dwell=4, mode_req for DOWN at dwell_cnt=1 with idx=5 -> idx holds until the boundary, then 4; mode_ack one cycle; req held through ack -> no second ack.
- run_en low at idx=3, dwell_cnt=2, for 10 cycles -> idx stays 3, running=0; on re-enable with dwell=4 -> step after 2 more edges.
- clr with mode_req the same cycle at idx=6 -> idx=0, IDLE, no ack that cycle; ack on the next edge. rst pulse mid-run -> all outputs at reset values immediately.
